sb_reg_file: RTL and testbench
==============================

# sb_reg_file

Parametrised register file with per-register scoreboard for the pipelined mini-RISC core. It provides NUM_RD combinational read ports, one synchronous write port with optional write-to-read bypass, and a hardwired-zero register option. A busy bit per register tracks in-flight producers, giving decode a ready-made stall signal. It sits between decode (read and reserve) and writeback (write and release).

## Interface
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; depth = 2**ADDR_W.
- NUM_RD, 2: number of read ports, 1..4.
- ZERO_REG, 1: 1 = register 0 always reads 0; writes and reserves to it are ignored.
- BYPASS, 1: 1 = same-cycle write data forwarded to matching read ports.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_req  in  NUM_RD  port k's operand is actually needed; qualifies stall only.
- rd_data  out  NUM_RD*DATA_W  read data per port.
- rd_busy  out  NUM_RD  the addressed register has an outstanding producer.
- stall  out  1  OR over k of (rd_req[k] & rd_busy[k]).
- wr_en  in  1  writeback strobe.
- wr_addr  in  ADDR_W  writeback destination.
- wr_data  in  DATA_W  writeback value.
- rsv_en  in  1  issue claims a destination register.
- rsv_addr  in  ADDR_W  claimed register.
- flush  in  1  pipeline flush; clears all busy bits.
- busy_cnt  out  ADDR_W+1  number of busy registers (registered).
- sb_err  out  1  sticky; reserve hit an already-busy register.

## Operation
- Storage: bank[0..2**ADDR_W-1] of DATA_W bits and busy[0..2**ADDR_W-1], 1 bit each.
- Write: on a clk edge with wr_en = 1, bank[wr_addr] <= wr_data. This is suppressed when ZERO_REG = 1 and wr_addr = 0.
- Release: a write also clears busy[wr_addr]. Writing a non-busy register is legal: the data is stored and busy stays 0.
- Reserve: on a clk edge with rsv_en = 1, busy[rsv_addr] <= 1. This is ignored when ZERO_REG = 1 and rsv_addr = 0.
  - If busy[rsv_addr] is already 1 (and no same-cycle release of that address), sb_err <= 1.
  - sb_err holds until reset.
- Same-cycle reserve and write to the same address: the reserve wins. The data is written and busy ends at 1, because a new producer has claimed the register. sb_err is not set.
- Flush: clears every busy bit and drops a same-cycle reserve. A same-cycle write still updates the bank. flush does not clear sb_err.
- Read, combinational per port k:
  - If ZERO_REG = 1 and the address is 0: rd_data = 0 and rd_busy = 0.
  - Otherwise, if BYPASS = 1 and wr_en = 1 and wr_addr = the address: rd_data = wr_data and rd_busy = 0.
  - Otherwise: rd_data = bank[address] and rd_busy = busy[address].
  - With BYPASS = 0, reads never forward: the written value appears from the next cycle, and rd_busy reflects the stored busy bit.
- A same-cycle reserve is not visible on rd_busy until the next cycle.
- busy_cnt: registered popcount of the next-state busy vector, so it always equals the popcount of the current busy.
- Any number of ports may read the same address; the results are identical.

## Timing
- Reset (rst_n = 0, asynchronous): all bank entries 0, all busy bits 0, busy_cnt = 0, sb_err = 0. rd_data and rd_busy follow combinationally (0 for every address); stall = 0.
- Reset asserted mid-operation discards all pending reservations and data immediately, with no clock required. The first edge after rst_n rises acts normally.
- Read latency: 0 cycles (combinational from rd_addr, and from wr_* when BYPASS = 1).
- Write latency: visible through bypass in the write cycle; visible from the bank on the cycle after the edge.
- Reserve-to-busy latency: 1 edge.
- Release-to-not-busy: same cycle with BYPASS = 1; 1 edge with BYPASS = 0.
- busy_cnt and sb_err update on the same edge as busy.
- stall has no registered state; it is purely combinational from rd_req, rd_addr, busy and wr_*.

## Test plan
- Reset/read: hold rst_n = 0, then release. Read r0..r31 on both ports -> all 0, stall = 0, busy_cnt = 0. Then assert rst_n = 0 between edges after writing r5 = 0x1234 -> r5 reads 0 immediately.
- Write/bypass (BYPASS = 1): wr r7 = 0xDEADBEEF with rd_addr0 = 7 in the same cycle -> rd_data0 = 0xDEADBEEF in that cycle. With BYPASS = 0 -> old value 0 that cycle, 0xDEADBEEF the next.
- Zero register: wr r0 = 0xFFFFFFFF and rsv r0 -> r0 reads 0, rd_busy = 0, busy_cnt unchanged.
- Scoreboard stall: rsv r3; the next cycle, rd_addr1 = 3 with rd_req = 2'b10 -> stall = 1, busy_cnt = 1. Then wr r3 = 42 -> the same cycle stall = 0 and rd_data1 = 42; the next cycle busy_cnt = 0.
- Collisions: rsv r9 with wr r9 = 5 in the same cycle -> busy[9] = 1, bank = 5, sb_err = 0. rsv r9 again the next cycle -> sb_err = 1 and it stays 1.
- Flush: reserve r1, r2, r4 (busy_cnt = 3). Assert flush with rsv r6 and wr r2 = 8 -> busy_cnt = 0, r6 not busy, r2 reads 8, sb_err unchanged.

Source files
------------

// File: rtl/sb_reg_file.sv
// Register file with a per-register busy scoreboard. It has combinational read ports, one write port and optional bypass.
// Reads take 0 cycles. Writes and reserves land on the clock edge. Stall is a combinational result of the busy bits.
module sb_reg_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   i_rd_addr,
  input  logic [NUM_RD-1:0]          i_rd_req,
  output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
  output logic [NUM_RD-1:0]          o_rd_busy,
  output logic                       o_stall,
  input  logic                       i_wr_en,
  input  logic [ADDR_W-1:0]          i_wr_addr,
  input  logic [DATA_W-1:0]          i_wr_data,
  input  logic                       i_rsv_en,
  input  logic [ADDR_W-1:0]          i_rsv_addr,
  input  logic                       i_flush,
  output logic [ADDR_W:0]            o_busy_cnt,
  output logic                       o_sb_err
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_bank [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic [ADDR_W:0]   r_busy_cnt;
  logic [ADDR_W:0]   w_cnt_nxt;
  logic              r_sb_err;
  logic              w_wr_ok;
  logic              w_rsv_ok;
  logic              w_rsv_hit;

  assign w_wr_ok  = i_wr_en && !(ZERO_REG != 0 && i_wr_addr == '0);
  assign w_rsv_ok = i_rsv_en && !i_flush && !(ZERO_REG != 0 && i_rsv_addr == '0);
  // A release of the same register in this cycle makes a re-reserve legal.
  assign w_rsv_hit = w_rsv_ok && r_busy[i_rsv_addr] &&
                     !(i_wr_en && i_wr_addr == i_rsv_addr);

  always_comb begin
    w_busy_nxt = r_busy;
    if (i_wr_en) w_busy_nxt[i_wr_addr] = 1'b0;
    if (i_flush) w_busy_nxt = '0;
    else if (w_rsv_ok) w_busy_nxt[i_rsv_addr] = 1'b1;
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cnt_nxt = w_cnt_nxt + {{ADDR_W{1'b0}}, w_busy_nxt[i]};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_bank[i] <= '0;
    end else if (w_wr_ok) begin
      r_bank[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
      r_sb_err   <= 1'b0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
      if (w_rsv_hit) r_sb_err <= 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_busy;

    assign w_addr = i_rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      w_data = r_bank[w_addr];
      w_busy = r_busy[w_addr];
      if (ZERO_REG != 0 && w_addr == '0) begin
        w_data = '0;
        w_busy = 1'b0;
      end else if (BYPASS != 0 && i_wr_en && i_wr_addr == w_addr) begin
        w_data = i_wr_data;
        w_busy = 1'b0;
      end
    end

    assign o_rd_data[k*DATA_W +: DATA_W] = w_data;
    assign o_rd_busy[k]                  = w_busy;
  end

  assign o_stall    = |(i_rd_req & o_rd_busy);
  assign o_busy_cnt = r_busy_cnt;
  assign o_sb_err   = r_sb_err;

endmodule

// File: tb/tb_sb_reg_file.sv
// Bench for sb_reg_file. It drives a bypass instance and a non-bypass instance from the same stimulus.
// A behavioural model is checked against both instances on every falling edge. Directed literal checks pin the model.
module tb_sb_reg_file;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [1:0]  rd_req;
  logic        wr_en, rsv_en, flush;
  logic [4:0]  wr_addr, rsv_addr;
  logic [31:0] wr_data;

  logic [63:0] b1_data, b0_data;
  logic [1:0]  b1_busy, b0_busy;
  logic        b1_stall, b0_stall, b1_err, b0_err;
  logic [5:0]  b1_cnt, b0_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sb_reg_file #(.BYPASS(1)) u_b1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_addr(rd_addr), .i_rd_req(rd_req),
    .o_rd_data(b1_data), .o_rd_busy(b1_busy), .o_stall(b1_stall),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr), .i_flush(flush),
    .o_busy_cnt(b1_cnt), .o_sb_err(b1_err));

  sb_reg_file #(.BYPASS(0)) u_b0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_addr(rd_addr), .i_rd_req(rd_req),
    .o_rd_data(b0_data), .o_rd_busy(b0_busy), .o_stall(b0_stall),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr), .i_flush(flush),
    .o_busy_cnt(b0_cnt), .o_sb_err(b0_err));

  // Behavioural model: plain arrays plus the architectural rules.
  logic [31:0] m_bank [32];
  bit          m_busy [32];
  bit          m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin m_bank[i] = 0; m_busy[i] = 0; end
      m_err = 0;
    end else begin
      if (rsv_en && rsv_addr != 0 && !flush && m_busy[rsv_addr] &&
          !(wr_en && wr_addr == rsv_addr)) m_err = 1;
      if (wr_en && wr_addr != 0) m_bank[wr_addr] = wr_data;
      if (wr_en) m_busy[wr_addr] = 0;
      if (flush) for (int i = 0; i < 32; i++) m_busy[i] = 0;
      else if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1;
    end
  end

  function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
    if (a == 0) return 0;
    if (byp && wr_en && wr_addr == a) return wr_data;
    return m_bank[a];
  endfunction

  function automatic bit exp_busy(input logic [4:0] a, input bit byp);
    if (a == 0) return 0;
    if (byp && wr_en && wr_addr == a) return 0;
    return m_busy[a];
  endfunction

  function automatic int popcnt();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [4:0] a;
    bit st1, st0;
    st1 = 0; st0 = 0;
    for (int k = 0; k < 2; k++) begin
      a = rd_addr[k*5 +: 5];
      chk($sformatf("cmp b1 data%0d", k), 64'(b1_data[k*32 +: 32]), 64'(exp_data(a, 1)));
      chk($sformatf("cmp b0 data%0d", k), 64'(b0_data[k*32 +: 32]), 64'(exp_data(a, 0)));
      chk($sformatf("cmp b1 busy%0d", k), 64'(b1_busy[k]), 64'(exp_busy(a, 1)));
      chk($sformatf("cmp b0 busy%0d", k), 64'(b0_busy[k]), 64'(exp_busy(a, 0)));
      st1 |= rd_req[k] & exp_busy(a, 1);
      st0 |= rd_req[k] & exp_busy(a, 0);
    end
    chk("cmp b1 stall", 64'(b1_stall), 64'(st1));
    chk("cmp b0 stall", 64'(b0_stall), 64'(st0));
    chk("cmp b1 cnt", 64'(b1_cnt), 64'(popcnt()));
    chk("cmp b0 cnt", 64'(b0_cnt), 64'(popcnt()));
    chk("cmp b1 err", 64'(b1_err), 64'(m_err));
    chk("cmp b0 err", 64'(b0_err), 64'(m_err));
  end

  // One cycle of stimulus. Inputs change 2 time units after the rising edge, and the directed checks follow 1 unit later.
  task automatic cyc(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                     input bit re, input logic [4:0] ra, input bit fl,
                     input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] rq);
    @(posedge clk);
    #2;
    wr_en = we; wr_addr = wa; wr_data = wd;
    rsv_en = re; rsv_addr = ra; flush = fl;
    rd_addr = {a1, a0}; rd_req = rq;
    #1;
  endtask

  task automatic idle(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] rq);
    cyc(0, 0, 0, 0, 0, 0, a0, a1, rq);
  endtask

  initial begin
    rst_n = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    rsv_en = 0; rsv_addr = 0; flush = 0; rd_addr = 0; rd_req = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;

    // Reset state on every address, with both ports on the same address.
    for (int a = 0; a < 32; a++) begin
      idle(5'(a), 5'(a), 2'b11);
      chk("rst data0", b1_data[31:0], 0);
      chk("rst data1", b1_data[63:32], 0);
      chk("rst stall", 64'(b1_stall), 0);
      chk("rst cnt", 64'(b1_cnt), 0);
    end

    // Write r5, then apply an asynchronous reset between clock edges.
    cyc(1, 5, 32'h1234, 0, 0, 0, 5, 0, 0);
    idle(5, 0, 0);
    chk("r5 stored b0", b0_data[31:0], 32'h1234);
    #1 rst_n = 0;
    #1;
    chk("async rst b1", b1_data[31:0], 0);
    chk("async rst b0", b0_data[31:0], 0);
    @(posedge clk);
    #2 rst_n = 1;

    // Write bypass versus no bypass.
    cyc(1, 7, 32'hDEADBEEF, 0, 0, 0, 7, 0, 0);
    chk("bypass b1", b1_data[31:0], 32'hDEADBEEF);
    chk("nobypass b0", b0_data[31:0], 0);
    idle(7, 0, 0);
    chk("nobypass next b0", b0_data[31:0], 32'hDEADBEEF);

    // Hardwired zero register.
    cyc(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 2'b01);
    chk("r0 data", b1_data[31:0], 0);
    chk("r0 busy", 64'(b1_busy[0]), 0);
    idle(0, 0, 2'b01);
    chk("r0 cnt", 64'(b1_cnt), 0);
    chk("r0 data next", b0_data[31:0], 0);

    // Scoreboard stall and release.
    cyc(0, 0, 0, 1, 3, 0, 0, 0, 0);
    idle(0, 3, 2'b10);
    chk("stall b1", 64'(b1_stall), 1);
    chk("stall cnt", 64'(b1_cnt), 1);
    cyc(1, 3, 42, 0, 0, 0, 0, 3, 2'b10);
    chk("release stall b1", 64'(b1_stall), 0);
    chk("release data b1", b1_data[63:32], 42);
    chk("release stall b0", 64'(b0_stall), 1);
    idle(0, 3, 2'b10);
    chk("release cnt", 64'(b1_cnt), 0);
    chk("release stall b0 next", 64'(b0_stall), 0);

    // Same-cycle reserve and write, then a double reserve.
    cyc(1, 9, 5, 1, 9, 0, 9, 0, 0);
    cyc(0, 0, 0, 1, 9, 0, 9, 0, 2'b01);
    chk("collide busy", 64'(b1_busy[0]), 1);
    chk("collide data", b1_data[31:0], 5);
    chk("collide err", 64'(b1_err), 0);
    idle(9, 0, 0);
    chk("double rsv err", 64'(b1_err), 1);
    idle(0, 0, 0);
    chk("err sticky", 64'(b0_err), 1);

    // Flush.
    cyc(1, 9, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 2, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 4, 0, 0, 0, 0);
    idle(0, 0, 0);
    chk("pre flush cnt", 64'(b1_cnt), 3);
    cyc(1, 2, 8, 1, 6, 1, 2, 6, 0);
    idle(2, 6, 2'b11);
    chk("flush cnt", 64'(b1_cnt), 0);
    chk("flush r6 busy", 64'(b1_busy[1]), 0);
    chk("flush r2 data", b0_data[31:0], 8);
    chk("flush err kept", 64'(b1_err), 1);

    // Mixed traffic. The model checks it on every cycle.
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
          $urandom_range(0, 15) == 0,
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 2'($urandom));
    end
    idle(0, 0, 0);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
